// File: rtl/mem_arbiter_if.sv
// Bundle of CPU, debug/loader and RAM-side signals around mem_arbiter.
// slave = arbiter view, master = the surrounding CPU/debug/RAM environment.
interface mem_arbiter_if;
    logic [1:0]  cpu_mem_cmd;
    logic [8:0]  cpu_mem_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_stall;

    logic        dbg_req;
    logic        dbg_we;
    logic [7:0]  dbg_addr;
    logic [15:0] dbg_wdata;
    logic        dbg_gnt;
    logic        dbg_done;
    logic [15:0] dbg_rdata;

    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    modport slave (
        input  cpu_mem_cmd, cpu_mem_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_done, dbg_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_mem_cmd, cpu_mem_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_done, dbg_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, debug loader) arbiter in front of a single-port synchronous RAM.
// Define ARB_ROUND_ROBIN_EN to alternate grants under contention instead of fixed CPU priority.
module mem_arbiter (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CPU_ACC = 2'd1;
    localparam logic [1:0] S_DBG_ACC = 2'd2;
    localparam logic [1:0] S_RSP     = 2'd3;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] dbg_rdata_q, dbg_rdata_d;

    logic cpu_pend;
    logic pick_dbg;
    logic rsp_cpu;
    logic rsp_dbg;

    // Address bit 8 selects I/O space, which never touches the RAM.
    assign cpu_pend = ((bus.cpu_mem_cmd == MREAD) || (bus.cpu_mem_cmd == MWRITE))
                      && !bus.cpu_mem_addr[8];

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_q, last_owner_d;

    assign pick_dbg = bus.dbg_req && (!cpu_pend || (last_owner_q == OWN_CPU));
`else
    assign pick_dbg = bus.dbg_req && !cpu_pend;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_dbg) begin
                    state_d = S_DBG_ACC;
                    owner_d = OWN_DBG;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_d = OWN_DBG;
`endif
                end else if (cpu_pend) begin
                    state_d = S_CPU_ACC;
                    owner_d = OWN_CPU;
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_d = OWN_CPU;
`endif
                end
            end
            S_CPU_ACC, S_DBG_ACC: state_d = S_RSP;
            S_RSP: begin
                state_d = S_IDLE;
                if (owner_q == OWN_CPU) cpu_rdata_d = bus.ram_rdata;
                else                    dbg_rdata_d = bus.ram_rdata;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_CPU;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= OWN_DBG;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    // RAM strobes decode straight from state, so reset drops a write pulse at once.
    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        bus.ram_we    = 1'b0;
        case (state_q)
            S_CPU_ACC: begin
                bus.ram_addr  = bus.cpu_mem_addr[7:0];
                bus.ram_wdata = bus.cpu_wdata;
                bus.ram_we    = (bus.cpu_mem_cmd == MWRITE);
            end
            S_DBG_ACC: begin
                bus.ram_addr  = bus.dbg_addr;
                bus.ram_wdata = bus.dbg_wdata;
                bus.ram_we    = bus.dbg_we;
            end
            default: ;
        endcase
    end

    assign rsp_cpu = (state_q == S_RSP) && (owner_q == OWN_CPU);
    assign rsp_dbg = (state_q == S_RSP) && (owner_q == OWN_DBG);

    assign bus.cpu_stall = cpu_pend && !rsp_cpu;
    assign bus.dbg_gnt   = (state_q == S_DBG_ACC);
    assign bus.dbg_done  = rsp_dbg;

    // Read data bypasses the holding register in RSP so the requester sees it
    // in the same cycle its stall drops / done pulses.
    assign bus.cpu_rdata = rsp_cpu ? bus.ram_rdata : cpu_rdata_q;
    assign bus.dbg_rdata = rsp_dbg ? bus.ram_rdata : dbg_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model with a
// behavioural RAM, directed corner cases plus randomized CPU/debug traffic.
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous RAM (read-first) seen by the DUT.
    logic [15:0] ram_mem [256];
    always @(posedge clk) begin
        bus.ram_rdata <= ram_mem[bus.ram_addr];
        if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    end

    // Reference model state.
    logic [15:0] ref_mem [256];
    bit          last_dbg;
    logic [15:0] cpu_prev;
    logic [15:0] dbg_prev;

    int n_checks = 0;
    int n_fail   = 0;
    int round_no = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (round %0d, t=%0t): got %h, expected %h", tag, round_no, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_access(input logic [7:0] a, input bit we, input logic [15:0] wd);
        logic [15:0] old;
        old = ref_mem[a];
        if (we) ref_mem[a] = wd;
        return old;
    endfunction

    // cop: 0 none, 1 read, 2 write, 3 I/O (bit 8 forced). dop: 0 none, 1 read, 2 write.
    task automatic run_round(input int cop, input logic [8:0] caddr_in, input logic [15:0] cwd,
                             input int dop, input logic [7:0] daddr, input logic [15:0] dwd);
        bit          cpu_ram, dbg_ram, cpu_first;
        int          cpu_acc, cpu_rsp, dbg_acc, dbg_rsp, len;
        logic [8:0]  caddr;
        logic [1:0]  ccmd;
        logic [15:0] cpu_new, dbg_new;
        logic        exp_we;
        logic [7:0]  exp_addr;
        logic [15:0] exp_wd;

        round_no++;
        cpu_ram = (cop == 1) || (cop == 2);
        dbg_ram = (dop != 0);
        caddr   = caddr_in;
        case (cop)
            1:       begin ccmd = 2'b01; caddr[8] = 1'b0; end
            2:       begin ccmd = 2'b10; caddr[8] = 1'b0; end
            3:       begin ccmd = cwd[0] ? 2'b10 : 2'b01; caddr[8] = 1'b1; end
            default: ccmd = 2'b00;
        endcase

        cpu_first = cpu_ram && (!dbg_ram || !RR || last_dbg);
        cpu_acc = -1; cpu_rsp = -1; dbg_acc = -1; dbg_rsp = -1;
        if (cpu_ram) begin cpu_acc = cpu_first ? 1 : 4; cpu_rsp = cpu_acc + 1; end
        if (dbg_ram) begin dbg_acc = cpu_first ? 4 : 1; dbg_rsp = dbg_acc + 1; end
        len = (cpu_rsp > dbg_rsp ? cpu_rsp : dbg_rsp) + 1;
        if (len < 2) len = 2;

        cpu_new = cpu_prev;
        dbg_new = dbg_prev;
        if (cpu_first) begin
            cpu_new = mem_access(caddr[7:0], cop == 2, cwd);
            if (dbg_ram) dbg_new = mem_access(daddr, dop == 2, dwd);
        end else begin
            if (dbg_ram) dbg_new = mem_access(daddr, dop == 2, dwd);
            if (cpu_ram) cpu_new = mem_access(caddr[7:0], cop == 2, cwd);
        end
        if (cpu_ram && dbg_ram) last_dbg = cpu_first;
        else if (cpu_ram || dbg_ram) last_dbg = dbg_ram;

        @(posedge clk);
        #1;
        bus.cpu_mem_cmd  = ccmd;
        bus.cpu_mem_addr = caddr;
        bus.cpu_wdata    = cwd;
        bus.dbg_req      = dbg_ram;
        bus.dbg_we       = (dop == 2);
        bus.dbg_addr     = daddr;
        bus.dbg_wdata    = dwd;

        for (int k = 0; k < len; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
                if (k - 1 == cpu_rsp) bus.cpu_mem_cmd = 2'b00;
                if (k - 1 == dbg_rsp) bus.dbg_req = 1'b0;
            end
            @(negedge clk);
            exp_we = 1'b0; exp_addr = '0; exp_wd = '0;
            if (k == cpu_acc) begin
                exp_we = (cop == 2); exp_addr = caddr[7:0]; exp_wd = cwd;
            end else if (k == dbg_acc) begin
                exp_we = (dop == 2); exp_addr = daddr; exp_wd = dwd;
            end
            check("cpu_stall", 32'(bus.cpu_stall), 32'(cpu_ram && (k < cpu_rsp)));
            check("dbg_gnt",   32'(bus.dbg_gnt),   32'(k == dbg_acc));
            check("dbg_done",  32'(bus.dbg_done),  32'(k == dbg_rsp));
            check("ram_we",    32'(bus.ram_we),    32'(exp_we));
            check("ram_addr",  32'(bus.ram_addr),  32'(exp_addr));
            check("ram_wdata", 32'(bus.ram_wdata), 32'(exp_wd));
            check("cpu_rdata", 32'(bus.cpu_rdata), 32'((cpu_ram && k >= cpu_rsp) ? cpu_new : cpu_prev));
            check("dbg_rdata", 32'(bus.dbg_rdata), 32'((dbg_ram && k >= dbg_rsp) ? dbg_new : dbg_prev));
        end

        cpu_prev = cpu_new;
        dbg_prev = dbg_new;
    endtask

    function automatic logic [7:0] rand_addr();
        logic [3:0] hi;
        hi = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        return {hi, 4'($urandom)};
    endfunction

    initial begin
        logic [7:0]  rst_addr;
        logic [15:0] rst_old;

        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 16'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        ram_mem[5] = 16'h1234;
        ref_mem[5] = 16'h1234;
        last_dbg = 1'b1;
        cpu_prev = '0;
        dbg_prev = '0;

        bus.cpu_mem_cmd = 2'b00; bus.cpu_mem_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;

        #1 reset = 1'b1;
        #1;
        check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
        check("rst_dbg_rdata", 32'(bus.dbg_rdata), 32'h0);
        check("rst_dbg_gnt",   32'(bus.dbg_gnt),   32'h0);
        check("rst_dbg_done",  32'(bus.dbg_done),  32'h0);
        check("rst_ram_we",    32'(bus.ram_we),    32'h0);
        check("rst_cpu_stall", 32'(bus.cpu_stall), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // Directed cases.
        run_round(1, 9'h005, 16'h0000, 0, 8'h00, 16'h0000);
        run_round(2, 9'h07C, 16'd42,   0, 8'h00, 16'h0000);
        run_round(1, 9'h07C, 16'h0000, 0, 8'h00, 16'h0000);
        run_round(3, 9'h140, 16'h0000, 0, 8'h00, 16'h0000);
        run_round(3, 9'h17C, 16'h0001, 0, 8'h00, 16'h0000);
        run_round(0, 9'h005, 16'h0000, 1, 8'h05, 16'h0000);
        for (int i = 0; i < 4; i++)
            run_round(1, 9'(rand_addr()), 16'h0000, 1, rand_addr(), 16'h0000);
        run_round(2, 9'h033, 16'hAAAA, 2, 8'h33, 16'h5555);
        run_round(1, 9'h033, 16'h0000, 0, 8'h00, 16'h0000);
        run_round(3, 9'h1FF, 16'h0000, 2, 8'hFF, 16'hBEEF);

        // Randomized traffic.
        for (int i = 0; i < 200; i++)
            run_round(int'($urandom_range(0, 3)), {1'($urandom), rand_addr()}, 16'($urandom),
                      int'($urandom_range(0, 2)), rand_addr(), 16'($urandom));

        // Reset during a debug write: pulse must die immediately, RAM untouched.
        rst_addr = 8'h9A;
        rst_old  = ref_mem[rst_addr];
        @(posedge clk);
        #1;
        bus.cpu_mem_cmd = 2'b00;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = rst_addr; bus.dbg_wdata = ~rst_old;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_gnt_before", 32'(bus.dbg_gnt), 32'h1);
        check("rst_mid_we_before",  32'(bus.ram_we),  32'h1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_we",       32'(bus.ram_we),    32'h0);
        check("rst_mid_gnt",      32'(bus.dbg_gnt),   32'h0);
        check("rst_mid_done",     32'(bus.dbg_done),  32'h0);
        check("rst_mid_dbg_rdata", 32'(bus.dbg_rdata), 32'h0);
        check("rst_mid_cpu_rdata", 32'(bus.cpu_rdata), 32'h0);
        @(posedge clk);
        #1;
        check("rst_mid_done_after", 32'(bus.dbg_done), 32'h0);
        check("rst_mid_we_after",   32'(bus.ram_we),   32'h0);
        bus.dbg_req = 1'b0;
        @(negedge clk) reset = 1'b0;
        last_dbg = 1'b1;
        cpu_prev = '0;
        dbg_prev = '0;
        run_round(1, {1'b0, rst_addr}, 16'h0000, 0, 8'h00, 16'h0000);
        check("rst_mem_unchanged", 32'(ref_mem[rst_addr]), 32'(rst_old));
        run_round(1, 9'h033, 16'h0000, 1, 8'h7C, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
